// File: rtl/serial_deserializer.sv
// Serial-to-parallel word assembler with per-word bit order, sof resync
// and a single-entry valid/ready output register with sticky overrun.
module serial_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             lsb_first,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q, cnt_base, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_base, sreg_d;
  logic             order_q, order_use;
  logic             accept, complete, load, drop;

  // sof restarts the word from this bit: count and partial data are
  // treated as empty before the incoming bit is applied.
  always_comb begin
    accept    = enable & bit_valid;
    cnt_base  = sof ? '0 : cnt_q;
    sreg_base = sof ? '0 : sreg_q;
    order_use = (cnt_base == '0) ? lsb_first : order_q;
    sreg_d    = order_use ? {bit_in, sreg_base[WIDTH-1:1]}
                          : {sreg_base[WIDTH-2:0], bit_in};
    complete  = accept && (cnt_base == LAST);
    cnt_d     = complete ? '0 : cnt_base + 1'b1;
    load      = complete && (!out_valid || out_ready);
    drop      = complete && out_valid && !out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sreg_q  <= '0;
      order_q <= 1'b1;
    end else if (accept) begin
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      order_q <= order_use;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept && sof && (cnt_q != '0);
      if (load) begin
        out_data  <= sreg_d;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // a fresh drop wins over a same-cycle clear
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed vector bench for serial_deserializer (WIDTH=8).
module tb_serial_deserializer;

  logic       clk, rst_n, enable, lsb_first, bit_valid, bit_in, sof;
  logic       out_ready, clr_overrun;
  logic [7:0] out_data;
  logic       out_valid, busy, overrun, frame_err;

  int n_cmp = 0;
  int n_err = 0;

  serial_deserializer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lsb_first(lsb_first),
    .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .frame_err(frame_err),
    .clr_overrun(clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en, lsb, bv, bi, sof, rdy, clr;
    logic [7:0] d;
    logic       v, b, o, f;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic en, lsb, bv, bi, sf, rdy, clr,
                     input logic [7:0] d, input logic v, b, o, f);
    vec_t x;
    x.en = en; x.lsb = lsb; x.bv = bv; x.bi = bi; x.sof = sf;
    x.rdy = rdy; x.clr = clr; x.d = d; x.v = v; x.b = b; x.o = o; x.f = f;
    tbl.push_back(x);
  endtask

  // seq[7] is sent first. Expected outputs are "mid" for bits 1..7 and
  // "end" after bit 8. gap>0 inserts two non-accepting cycles per bit:
  // one with bit_valid=0, one with enable=0 but bit_valid and sof high.
  task automatic add_word(input logic lsb0, lsb_rest, input logic [7:0] seq,
                          input logic sof0, ferr0, rdy_last, clr_last,
                          input logic [7:0] d_mid, input logic v_mid, o_mid,
                          input logic [7:0] d_end, input logic v_end, o_end,
                          input int gap);
    for (int i = 0; i < 8; i++) begin
      logic last;
      last = (i == 7);
      add(1'b1, (i == 0) ? lsb0 : lsb_rest, 1'b1, seq[7-i], sof0 && (i == 0),
          last ? rdy_last : 1'b0, last ? clr_last : 1'b0,
          last ? d_end : d_mid, last ? v_end : v_mid, !last,
          last ? o_end : o_mid, (i == 0) ? ferr0 : 1'b0);
      if (gap > 0 && !last) begin
        add(1'b1, lsb_rest, 1'b0, ~seq[7-i], 1'b0, 1'b0, 1'b0, d_mid, v_mid, 1'b1, o_mid, 1'b0);
        add(1'b0, ~lsb_rest, 1'b1, ~seq[7-i], 1'b1, 1'b0, 1'b0, d_mid, v_mid, 1'b1, o_mid, 1'b0);
      end
    end
  endtask

  task automatic drive(input logic en, lsb, bv, bi, sf, rdy, clr);
    enable = en; lsb_first = lsb; bit_valid = bv; bit_in = bi; sof = sf;
    out_ready = rdy; clr_overrun = clr;
  endtask

  task automatic check_all(input string tag, input int idx, input logic [7:0] d,
                           input logic v, b, o, f);
    check({tag, ".out_data"},  idx, 32'(out_data),  32'(d));
    check({tag, ".out_valid"}, idx, 32'(out_valid), 32'(v));
    check({tag, ".busy"},      idx, 32'(busy),      32'(b));
    check({tag, ".overrun"},   idx, 32'(overrun),   32'(o));
    check({tag, ".frame_err"}, idx, 32'(frame_err), 32'(f));
  endtask

  initial begin
    // 4D LSB first, back to back
    add_word(1, 1, 8'b10110010, 0, 0, 0, 0, 8'h00, 0, 0, 8'h4D, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 8'h4D, 0, 0, 0, 0);
    // B2 MSB first with two dead cycles between bits
    add_word(0, 0, 8'b10110010, 0, 0, 0, 0, 8'h4D, 0, 0, 8'hB2, 1, 0, 2);
    add(1, 0, 0, 0, 0, 1, 0, 8'hB2, 0, 0, 0, 0);
    // A5 (sof at count 0: no frame_err), then 3C dropped with out_ready=0
    add_word(1, 1, 8'b10100101, 1, 0, 0, 0, 8'hB2, 0, 0, 8'hA5, 1, 0, 0);
    add_word(1, 1, 8'b00111100, 0, 0, 0, 0, 8'hA5, 1, 0, 8'hA5, 1, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 8'hA5, 1, 0, 0, 0);
    // 5A completes on the same edge A5 is consumed
    add_word(1, 1, 8'b01011010, 0, 0, 1, 0, 8'hA5, 1, 0, 8'h5A, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 8'h5A, 0, 0, 0, 0);
    // three stray bits, sof restarts as MSB-first 96 with lsb_first toggled after
    add(1, 1, 1, 1, 0, 0, 0, 8'h5A, 0, 1, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 8'h5A, 0, 1, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 8'h5A, 0, 1, 0, 0);
    add_word(0, 1, 8'b10010110, 1, 1, 0, 0, 8'h5A, 0, 0, 8'h96, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 8'h96, 0, 0, 0, 0);
    // overrun raised on the same edge clr_overrun is asserted stays set
    add_word(1, 1, 8'hFF, 0, 0, 0, 0, 8'h96, 0, 0, 8'hFF, 1, 0, 0);
    add_word(1, 1, 8'h00, 0, 0, 0, 1, 8'hFF, 1, 0, 8'hFF, 1, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 8'hFF, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 8'hFF, 0, 0, 0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 8'h00, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].lsb, tbl[i].bv, tbl[i].bi, tbl[i].sof,
            tbl[i].rdy, tbl[i].clr);
      @(posedge clk);
      #1;
      check_all("tbl", i, tbl[i].d, tbl[i].v, tbl[i].b, tbl[i].o, tbl[i].f);
    end

    // Fill output register, then reset mid-word after 5 bits
    for (int i = 0; i < 13; i++) begin
      drive(1, 1, 1, 1, 0, 0, 0);
      @(posedge clk);
      #1;
    end
    check_all("pre_rst", 0, 8'hFF, 1, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_all("in_rst", 0, 8'h00, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all("in_rst", 1, 8'h00, 0, 0, 0, 0);
    rst_n = 1'b1;
    begin
      logic [7:0] seq;
      seq = 8'b10110010;
      for (int i = 0; i < 8; i++) begin
        drive(1, 1, 1, seq[7-i], 0, 0, 0);
        @(posedge clk);
        #1;
        check("post_rst.frame_err", i, 32'(frame_err), 32'd0);
        check("post_rst.busy", i, 32'(busy), (i < 7) ? 32'd1 : 32'd0);
      end
    end
    check_all("post_rst", 8, 8'h4D, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  accept serial bits when 1; output handshake unaffected by enable.
REQ-005 SHALL have port lsb_first  input  1  bit order of the next word: 1 = LSB first, 0 = MSB first.
REQ-006 SHALL have port bit_valid  input  1  bit_in carries a bit this cycle.
REQ-007 SHALL have port bit_in  input  1  serial data bit.
REQ-008 SHALL have port sof  input  1  start of frame; qualified by bit_valid; marks bit_in as bit 0 of a new word.
REQ-009 SHALL have port out_data  output  WIDTH  assembled word.
REQ-010 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-011 SHALL have port out_ready  input  1  consumer accepts word when out_valid && out_ready.
REQ-012 SHALL have port busy  output  1  partial word in progress (bit count != 0).
REQ-013 SHALL have port overrun  output  1  sticky: a completed word was dropped.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse: partial word discarded by sof.
REQ-015 SHALL have port clr_overrun  input  1  clears overrun.

Function
REQ-016 SHALL accept a bit only in a cycle with enable=1 and bit_valid=1; other cycles leave the shift register and bit counter unchanged.
REQ-017 SHALL latch lsb_first when bit 0 of a word is accepted and use that latched order for the whole word; mid-word changes are ignored.
REQ-018 SHALL, for LSB-first order, shift the assembly register right, bit_in entering bit WIDTH-1; after WIDTH bits the first bit received sits at bit 0.
REQ-019 SHALL, for MSB-first order, shift the assembly register left, bit_in entering bit 0; after WIDTH bits the first bit received sits at bit WIDTH-1.
REQ-020 SHALL count accepted bits 0..WIDTH-1; on acceptance of bit WIDTH-1 the word completes and the counter wraps to 0 on the same edge.
REQ-021 SHALL, on completion, load the full word into out_data and set out_valid on that same edge (out_valid visible one clock after the last bit is sampled).
REQ-022 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL clear out_valid on the edge where out_valid && out_ready, unless a word completes on that same edge, in which case out_valid stays 1 and out_data takes the new word.
REQ-024 SHALL, when a word completes while out_valid=1 and out_ready=0, discard the new word, keep the held word, and set overrun.
REQ-025 SHALL keep overrun at 1 until clr_overrun=1 or reset; clr_overrun and a simultaneous new overrun leave overrun=1.
REQ-026 SHALL, on an accepted bit with sof=1, discard any partial word, treat bit_in as bit 0 (counter becomes 1), and latch lsb_first.
REQ-027 SHALL pulse frame_err for exactly one cycle when sof arrives with bit count != 0; sof at count 0 produces no frame_err.
REQ-028 SHALL ignore sof when bit_valid=0 or enable=0.
REQ-029 SHALL drive busy = (bit count != 0) as a registered-state decode.

Reset
REQ-030 SHALL, while rst_n=0, force out_data=0, out_valid=0, busy=0, overrun=0, frame_err=0, bit counter=0, assembly register=0, latched order=LSB-first.
REQ-031 SHALL, on rst_n assertion mid-word, discard the partial word immediately with no frame_err; the first accepted bit after release is bit 0.

Verification
REQ-032 SHALL verify WIDTH=8, lsb_first=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> out_data=8'h4D, out_valid=1 one clock after the 8th bit.
REQ-033 SHALL verify WIDTH=8, lsb_first=0, same bit sequence with bit_valid gaps of 2 idle cycles -> out_data=8'hB2; busy=1 throughout, 0 after completion.
REQ-034 SHALL verify out_ready=0, two full words 8'hA5 then 8'h3C -> out_data stays 8'hA5, overrun=1; clr_overrun pulse -> overrun=0.
REQ-035 SHALL verify out_ready=1 on the completion edge of a second word -> out_valid stays 1, out_data updates to second word, overrun=0.
REQ-036 SHALL verify sof after 3 bits -> frame_err one-cycle pulse, next word assembled from the sof bit onward; lsb_first toggled mid-word has no effect.
REQ-037 SHALL verify rst_n low for one cycle after 5 bits -> all outputs 0, following 8 bits produce one correct word, frame_err never asserted.
